mem_bus_arbiter: RTL

- Shares one single-outstanding memory bus between the instruction-fetch port (pcF/instrF) and the data port (aluoutM/writedataM/sig_write/memwriteM/readdataM) of the 5-stage datapath.
- Sits between datapath and the memory/bridge.
- Serialises requests with a 3-state FSM and holds each requester stalled until its transaction completes.
- Drives per-port stall outputs for the hazard unit.

---
 rtl/mem_bus_arbiter_pkg.sv | 13 +
 rtl/arb_grant_sel.sv | 35 +++
 rtl/mem_bus_arbiter.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for mem_bus_arbiter: FSM state encoding and grant encoding.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SRV_INST = 2'd1,
    SRV_DATA = 2'd2
  } state_t;

  localparam logic GNT_INST = 1'b0;
  localparam logic GNT_DATA = 1'b1;

endpackage

// File: rtl/arb_grant_sel.sv
// Combinational winner selection for mem_bus_arbiter.
// A port whose valid pulse is high this cycle is masked so the requester
// gets one edge to drop or renew its request.
// MEM_BUS_ARBITER_RR_EN: round-robin on collision instead of data-first.
module arb_grant_sel
  import mem_bus_arbiter_pkg::*;
(
  input  logic inst_req,
  input  logic inst_valid,
  input  logic data_req,
  input  logic data_valid,
`ifdef MEM_BUS_ARBITER_RR_EN
  input  logic last_grant,
`endif
  output logic gnt,
  output logic gnt_sel
);

  logic inst_live;
  logic data_live;

  assign inst_live = inst_req & ~inst_valid;
  assign data_live = data_req & ~data_valid;

  // Pick a winner; data is older (MEM stage) so it wins ties by default.
  always_comb begin
    gnt     = inst_live | data_live;
    gnt_sel = data_live ? GNT_DATA : GNT_INST;
`ifdef MEM_BUS_ARBITER_RR_EN
    if (inst_live && data_live)
      gnt_sel = (last_grant == GNT_INST) ? GNT_DATA : GNT_INST;
`endif
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one single-outstanding memory bus between the
// instruction-fetch port and the data port. One transaction at a time,
// each requester stalled until its valid pulse.
// Optional: MEM_BUS_ARBITER_RR_EN selects round-robin arbitration.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic [DATA_W-1:0]   inst_rdata,
  output logic                inst_valid,
  output logic                inst_stall,
  input  logic                data_req,
  input  logic                data_wr,
  input  logic [DATA_W/8-1:0] data_wstrb,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                data_valid,
  output logic                data_stall,
  output logic                bus_req,
  output logic                bus_wr,
  output logic [DATA_W/8-1:0] bus_wstrb,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  input  logic                bus_ack,
  input  logic [DATA_W-1:0]   bus_rdata
);

  state_t state, state_nx;
  logic   gnt, gnt_sel;
  logic   grant_load, inst_done, data_done;

`ifdef MEM_BUS_ARBITER_RR_EN
  logic last_grant;

  // Remember the last winner so a collision goes to the other port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)            last_grant <= GNT_INST;
    else if (grant_load) last_grant <= gnt_sel;
  end
`endif

  arb_grant_sel u_sel (
    .inst_req   (inst_req),
    .inst_valid (inst_valid),
    .data_req   (data_req),
    .data_valid (data_valid),
`ifdef MEM_BUS_ARBITER_RR_EN
    .last_grant (last_grant),
`endif
    .gnt        (gnt),
    .gnt_sel    (gnt_sel)
  );

  assign inst_stall = inst_req & ~inst_valid;
  assign data_stall = data_req & ~data_valid;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Next state plus grant/completion strobes; bus_ack is only honoured
  // while a transaction is in flight.
  always_comb begin
    state_nx   = state;
    grant_load = 1'b0;
    inst_done  = 1'b0;
    data_done  = 1'b0;
    case (state)
      IDLE: begin
        if (gnt) begin
          grant_load = 1'b1;
          state_nx   = (gnt_sel == GNT_DATA) ? SRV_DATA : SRV_INST;
        end
      end
      SRV_INST: begin
        if (bus_ack) begin
          inst_done = 1'b1;
          state_nx  = IDLE;
        end
      end
      SRV_DATA: begin
        if (bus_ack) begin
          data_done = 1'b1;
          state_nx  = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Bus outputs latched at grant and held until ack; read data and the
  // one-cycle valid pulses captured on ack.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus_req    <= 1'b0;
      bus_wr     <= 1'b0;
      bus_wstrb  <= '0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
      inst_rdata <= '0;
      data_rdata <= '0;
      inst_valid <= 1'b0;
      data_valid <= 1'b0;
    end else begin
      inst_valid <= 1'b0;
      data_valid <= 1'b0;
      if (grant_load) begin
        bus_req <= 1'b1;
        if (gnt_sel == GNT_DATA) begin
          bus_addr  <= data_addr;
          bus_wr    <= data_wr;
          bus_wstrb <= data_wr ? data_wstrb : '0;
          bus_wdata <= data_wdata;
        end else begin
          bus_addr  <= inst_addr;
          bus_wr    <= 1'b0;
          bus_wstrb <= '0;
          bus_wdata <= '0;
        end
      end
      if (inst_done) begin
        bus_req    <= 1'b0;
        inst_rdata <= bus_rdata;
        inst_valid <= 1'b1;
      end
      if (data_done) begin
        bus_req    <= 1'b0;
        data_valid <= 1'b1;
        if (!bus_wr) data_rdata <= bus_rdata;
      end
    end
  end

endmodule
